// File: rtl/pe_float_pkg.sv
// Shared floating-point definitions for the PE datapath: derived format
// constants, operand classes, flag bit positions and the operand descriptor.
package pe_float_pkg;

  // Default format: IEEE binary32.
  localparam int FP32_EXP_W   = 8;
  localparam int FP32_MAN_W   = 23;
  localparam int FP32_W       = 1 + FP32_EXP_W + FP32_MAN_W;
  localparam int FP32_BIAS    = (1 << (FP32_EXP_W - 1)) - 1;
  localparam int FP32_EXP_MAX = (1 << FP32_EXP_W) - 1;

  // Exponent bias for an arbitrary exponent width.
  function automatic int f_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones exponent code (infinity / NaN) for an arbitrary exponent width.
  function automatic int f_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Operand / result class. Denormals are folded into ZERO.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_e;

  // Bit positions inside the 4-bit flag vector {overflow, underflow, inexact, invalid}.
  localparam int FLAG_OVF = 3;
  localparam int FLAG_UNF = 2;
  localparam int FLAG_INX = 1;
  localparam int FLAG_INV = 0;

  // Width-independent part of an unpacked operand.
  typedef struct packed {
    logic    sign;
    fclass_e cls;
  } op_info_t;

endpackage

// File: rtl/pe_float_round_pack.sv
// Normalise / round-to-nearest-even / pack for a raw mantissa product.
// The product holds two 1.x significands, so it lies in [1,4) and needs at
// most a one-bit right shift. Special classes bypass rounding. Shared with
// the adder datapath.
module pe_float_round_pack
  import pe_float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    sign,
  input  fclass_e                 cls,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [2*MAN_W+1:0]      prod,
  input  logic                    invalid,
  output logic [EXP_W+MAN_W:0]    res,
  output logic [3:0]              flags
);

  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S  = EW'(f_exp_max(EXP_W));
  localparam logic signed [EW-1:0] EXP_ZERO_S = '0;

  logic                 norm;
  logic [MAN_W-1:0]     frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [MAN_W:0]       frac_r;
  logic signed [EW-1:0] exp_f;

  // Select the fraction window and the guard/sticky bits below it.
  // NOTE: combinational blocks use blocking '=' and give every output a value
  // on every path, so no latch can be inferred.
  always_comb begin
    norm = prod[2*MAN_W+1];
    if (norm) begin
      frac   = prod[2*MAN_W:MAN_W+1];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
    end else begin
      frac   = prod[2*MAN_W-1:MAN_W];
      guard  = prod[MAN_W-1];
      sticky = |prod[MAN_W-2:0];
    end
  end

  // Round to nearest, ties to even; a carry out of the fraction bumps the exponent.
  always_comb begin
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    exp_f    = exp_in
             + $signed({{(EW-1){1'b0}}, norm})
             + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});
  end

  // Pack the result word and raise flags.
  always_comb begin
    res             = '0;
    flags           = '0;
    flags[FLAG_INV] = invalid;
    unique case (cls)
      CLS_ZERO: res = {sign, {(EXP_W+MAN_W){1'b0}}};
      CLS_INF:  res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_NAN:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      default: begin
        if (exp_f >= EXP_MAX_S) begin
          res             = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags[FLAG_OVF] = 1'b1;
          flags[FLAG_INX] = 1'b1;
        end else if (exp_f <= EXP_ZERO_S) begin
          // Denormal results flush to signed zero; the whole significand is lost.
          res             = {sign, {(EXP_W+MAN_W){1'b0}}};
          flags[FLAG_UNF] = 1'b1;
          flags[FLAG_INX] = 1'b1;
        end else begin
          res             = {sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
          flags[FLAG_INX] = guard | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/pe_mult_float_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake,
// full backpressure and a sideband tag.
//   S1: unpack, classify, sign, exponent sum minus bias
//   S2: significand multiply
//   S3: normalise / round / pack into the output registers
// Optional build macro IEEE_NAN_EN: Inf x 0 and NaN inputs produce the
// canonical quiet NaN; invalid is raised for Inf x 0 and signalling NaN
// inputs. Without it the exponent field alone decides the class (NaN acts
// as infinity) and Inf x 0 returns signed infinity with invalid.
module pe_mult_float_pipe
  import pe_float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_m,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam logic signed [EW-1:0] BIAS_S = EW'(f_bias(EXP_W));

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_free, s2_free, s3_free;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s3_free   = !s3_valid || out_ready;
  assign s2_free   = !s2_valid || s3_free;
  assign s1_free   = !s1_valid || s2_free;
  assign in_ready  = s1_free;
  assign out_valid = s3_valid;

  // Stage valid bits; reset drops everything in flight.
  // NOTE: sequential state is written with non-blocking '<=' so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_free) s1_valid <= in_valid;
      if (s2_free) s2_valid <= s1_valid;
      if (s3_free) s3_valid <= s2_valid;
    end
  end

  // ---------------- S1: unpack and classify ----------------
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  op_info_t             ia, ib;
  fclass_e              s1_cls_d;
  logic                 s1_inv_d;
  logic signed [EW-1:0] s1_exp_d;
`ifdef IEEE_NAN_EN
  logic                 a_snan, b_snan;
`endif

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;

  // Classify each operand; denormal encodings count as zero.
  always_comb begin
    ia.sign = sa;
    ib.sign = sb;
    ia.cls  = (ea == '0) ? CLS_ZERO : (ea == '1) ? CLS_INF : CLS_NORM;
    ib.cls  = (eb == '0) ? CLS_ZERO : (eb == '1) ? CLS_INF : CLS_NORM;
`ifdef IEEE_NAN_EN
    a_snan  = 1'b0;
    b_snan  = 1'b0;
    if (ea == '1 && fa != '0) begin
      ia.cls = CLS_NAN;
      a_snan = !fa[MAN_W-1];
    end
    if (eb == '1 && fb != '0) begin
      ib.cls = CLS_NAN;
      b_snan = !fb[MAN_W-1];
    end
`endif
  end

  // Decide the result class, invalid flag and biased exponent sum.
  always_comb begin
    s1_cls_d = CLS_NORM;
    s1_inv_d = 1'b0;
    s1_exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
`ifdef IEEE_NAN_EN
    if (ia.cls == CLS_NAN || ib.cls == CLS_NAN) begin
      s1_cls_d = CLS_NAN;
      s1_inv_d = a_snan | b_snan;
    end else if ((ia.cls == CLS_INF && ib.cls == CLS_ZERO) ||
                 (ia.cls == CLS_ZERO && ib.cls == CLS_INF)) begin
      s1_cls_d = CLS_NAN;
      s1_inv_d = 1'b1;
    end else
`else
    if ((ia.cls == CLS_INF && ib.cls == CLS_ZERO) ||
        (ia.cls == CLS_ZERO && ib.cls == CLS_INF)) begin
      s1_cls_d = CLS_INF;
      s1_inv_d = 1'b1;
    end else
`endif
    if (ia.cls == CLS_INF || ib.cls == CLS_INF) begin
      s1_cls_d = CLS_INF;
    end else if (ia.cls == CLS_ZERO || ib.cls == CLS_ZERO) begin
      s1_cls_d = CLS_ZERO;
    end
  end

  logic                 s1_sign;
  fclass_e              s1_cls;
  logic                 s1_inv;
  logic signed [EW-1:0] s1_exp;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic [TAG_W-1:0]     s1_tag;

  // S1 register bank.
  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (s1_free && in_valid) begin
      s1_sign <= ia.sign ^ ib.sign;
      s1_cls  <= s1_cls_d;
      s1_inv  <= s1_inv_d;
      s1_exp  <= s1_exp_d;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
      s1_tag  <= in_tag;
    end
  end

  // ---------------- S2: significand multiply ----------------
  logic                 s2_sign;
  fclass_e              s2_cls;
  logic                 s2_inv;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic [TAG_W-1:0]     s2_tag;

  // S2 register bank holding the full-width product.
  always_ff @(posedge clk) begin
    if (s2_free && s1_valid) begin
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_inv  <= s1_inv;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- S3: round, pack, output registers ----------------
  logic [W-1:0] rp_res;
  logic [3:0]   rp_flags;

  pe_float_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign    (s2_sign),
    .cls     (s2_cls),
    .exp_in  (s2_exp),
    .prod    (s2_prod),
    .invalid (s2_inv),
    .res     (rp_res),
    .flags   (rp_flags)
  );

  // Output registers: cleared by reset, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_m     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (s3_free && s2_valid) begin
      out_m     <= rp_res;
      out_tag   <= s2_tag;
      out_flags <= rp_flags;
    end
  end

endmodule

// File: doc/pe_mult_float_pipe.md
Name: pe_mult_float_pipe

Overview:
Pipelined, parametrised floating-point multiplier for the PE datapath. It is the sequential successor to the combinational mult_f32.
- Exponent and mantissa widths are configurable; the default is IEEE binary32.
- Fixed 3-stage pipeline with valid/ready handshake and full backpressure.
- A sideband tag travels with each operand pair so results can be matched to requests.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
TAG_W, 4, sideband tag width, carried unmodified alongside the data

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept the pair this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_m  out  W  product
out_tag  out  TAG_W  tag of the product
out_flags  out  4  {overflow, underflow, inexact, invalid}

Behaviour:
- Reset (sampled on clk edge while rst=1): all stage valid bits 0; out_valid=0; out_m=0; out_tag=0; out_flags=0. Reset mid-operation discards all in-flight data with no output.
- Transfers: input is accepted on in_valid&in_ready; output is retired on out_valid&out_ready.
- Pipeline: S1 -> S2 -> S3, one register bank each.
  - S1: unpack operands, sign = sa^sb, classify zero/inf/NaN/denormal, sum exponents minus bias.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa multiply.
  - S3: normalise (shift by at most 1), round, pack, register outputs.
- Latency: exactly 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 per cycle.
- Stall rules:
  - A stage advances when the next stage is empty or advancing.
  - in_ready = !S1_valid | S1_advance, so bubbles are squeezed out.
  - in_ready is combinational from out_ready; there is no skid buffer.
  - While out_valid=1 and out_ready=0, out_m, out_tag and out_flags hold stable.
- Rounding: round-to-nearest-even. inexact=1 if any discarded bit is nonzero.
- Denormal inputs are flushed to signed zero. Denormal results are flushed to signed zero with underflow=1.
- Exponent overflow gives signed infinity with overflow=1 and inexact=1. Rounding carry-out that pushes the exponent to all-ones is also overflow.
- Zero operand (finite other operand) gives signed zero.
- Inf x finite nonzero gives signed infinity.
- Inf x 0 gives infinity with sign = sa^sb and invalid=1. This keeps the existing mult_f32 result.
- NaN inputs: treated as infinity (the exponent field alone decides).
- Simultaneous accept and retire on the same cycle with a full pipeline is legal and sustains throughput.

Optional Feature:
IEEE_NAN_EN.
- Defined:
  - Inf x 0 returns canonical quiet NaN (sign 0, exponent all-ones, MSB of fraction 1; 0x7FC00000 for binary32) with invalid=1.
  - A NaN input propagates as the canonical quiet NaN; invalid=1 only if an input is a signalling NaN.
- Undefined: behaviour exactly as in Behaviour, with no NaN detection logic.

Decomposition:
- Package pe_float_pkg holds:
  - derived constants: W, BIAS = 2^(EXP_W-1)-1, EXP_MAX;
  - class enum {ZERO, NORM, INF, NAN};
  - flag bit index constants;
  - unpacked-operand struct typedef.
- One natural sub-module: pe_float_round_pack (the S3 combinational normalise/round/pack). It is reused later by the adder.

Test Plan:
1. Back-to-back stream with out_ready=1: (0x40200000,0x40400000) -> 0x40F00000; (0xBF8CCCCD,0x40A00000) -> 0xC0B00000, inexact=1. Each result appears 3 cycles after acceptance, one per cycle, tags in order.
2. Overflow/underflow:
   - 0x7F000000 x 0x40000000 -> 0x7F800000, overflow=1.
   - 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1.
   - 0x80800000 x 0x3F000000 -> 0x80000000, underflow=1.
3. Specials:
   - 0x7F800000 x 0x00000000 -> 0x7F800000, invalid=1 (IEEE_NAN_EN: 0x7FC00000).
   - 0xBF800000 x 0xFF800000 -> 0x7F800000.
   - 0x40400000 x 0x00000000 -> 0x00000000.
4. Backpressure: fill the pipeline with tags 0..5, hold out_ready=0 for 5 cycles -> in_ready=0 once 3 entries are held; out_m/out_tag stable. Release -> tags 0..5 retire in order, none lost or duplicated.
5. Reset mid-stream: assert rst for 1 cycle with 3 in flight -> out_valid=0 the next cycle, no stale result emitted; the following input's result returns after 3 cycles.
6. Parameter sweep at EXP_W=5, MAN_W=10 (binary16): 0x4100 x 0x4200 -> 0x4780 (2.5x3.0=7.5); 0x7800 x 0x4000 -> 0x7C00, overflow=1.
